// File: rtl/timer_responder.sv
// 16-bit timer/compare responder on the CPU IO bus: prescaled counter, compare match
// and overflow flags, a level interrupt, and an atomic LO/HI counter read via a shadow byte.
module timer_responder #(
    parameter logic [15:0] BASE_ADDR = 16'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dMemIOAddress,
    input  logic [7:0]  dMemIOIn,
    input  logic        dMemIOWriteEn,
    input  logic        dMemIOReadEn,
    output logic [7:0]  dMemIOOut,
    output logic        interrupt,
    input  logic        interrupt_clr
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_CMP_LO = 3'd1;
    localparam logic [2:0] OFF_CMP_HI = 3'd2;
    localparam logic [2:0] OFF_CNT_LO = 3'd3;
    localparam logic [2:0] OFF_CNT_HI = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    logic [6:0]  ctrl_q,   ctrl_d;
    logic [15:0] cmp_q,    cmp_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  pcnt_q,   pcnt_d;
    logic [7:0]  rdata_q,  rdata_d;
    logic        match_q,  match_d;
    logic        ovf_q,    ovf_d;
    logic        irq_q,    irq_d;

    logic        sel;
    logic [2:0]  off;
    logic        wr_sel;
    logic        rd_sel;
    logic [5:0]  wr_hit;
    logic        en;
    logic        autoreload;
    logic        irqen;
    logic [2:0]  ps;
    logic [7:0]  pcnt_limit;
    logic        tick;
    logic [15:0] cnt_ticked;
    logic        match_set;
    logic        ovf_set;
    logic        match_clr;
    logic        ovf_clr;

    assign sel    = (dMemIOAddress[15:3] == BASE_ADDR[15:3]);
    assign off    = dMemIOAddress[2:0];
    assign wr_sel = dMemIOWriteEn && sel;
    assign rd_sel = dMemIOReadEn && sel;

    for (genvar gi = 0; gi < 6; gi++) begin : g_wr_hit
        assign wr_hit[gi] = wr_sel && (off == 3'(gi));
    end

    assign en         = ctrl_q[0];
    assign autoreload = ctrl_q[1];
    assign irqen      = ctrl_q[2];
    assign ps         = ctrl_q[6:4];

    // Prescaler period is 2^PS cycles; PS=0 ticks every enabled cycle.
    assign pcnt_limit = (8'd1 << ps) - 8'd1;
    assign tick       = en && (pcnt_q == pcnt_limit);

    always_comb begin
        pcnt_d = pcnt_q;
        if (wr_hit[OFF_CTRL] || !en) begin
            pcnt_d = 8'd0;
        end else if (tick) begin
            pcnt_d = 8'd0;
        end else begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    // Compare takes priority over the wrap, so CMP=FFFF without autoreload never flags OVF.
    always_comb begin
        cnt_ticked = cnt_q;
        match_set  = 1'b0;
        ovf_set    = 1'b0;
        if (tick) begin
            if (cnt_q == cmp_q) begin
                match_set  = 1'b1;
                cnt_ticked = autoreload ? 16'h0000 : cnt_q + 16'd1;
            end else if (cnt_q == 16'hFFFF) begin
                ovf_set    = 1'b1;
                cnt_ticked = 16'h0000;
            end else begin
                cnt_ticked = cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        cmp_d  = cmp_q;
        cnt_d  = cnt_ticked;
        if (wr_hit[OFF_CTRL])   ctrl_d       = dMemIOIn[6:0];
        if (wr_hit[OFF_CMP_LO]) cmp_d[7:0]   = dMemIOIn;
        if (wr_hit[OFF_CMP_HI]) cmp_d[15:8]  = dMemIOIn;
        // A CPU byte write beats the tick; the untouched byte keeps its pre-tick value.
        if (wr_hit[OFF_CNT_LO]) cnt_d        = {cnt_q[15:8], dMemIOIn};
        if (wr_hit[OFF_CNT_HI]) cnt_d        = {dMemIOIn, cnt_q[7:0]};
    end

    assign match_clr = interrupt_clr || (wr_hit[OFF_STATUS] && dMemIOIn[0]);
    assign ovf_clr   = wr_hit[OFF_STATUS] && dMemIOIn[1];

    always_comb begin
        match_d = match_set || (match_q && !match_clr);
        ovf_d   = ovf_set   || (ovf_q   && !ovf_clr);
        irq_d   = match_q && irqen;
    end

    always_comb begin
        rdata_d  = 8'h00;
        shadow_d = shadow_q;
        if (rd_sel) begin
            case (off)
                OFF_CTRL:   rdata_d = {1'b0, ctrl_q};
                OFF_CMP_LO: rdata_d = cmp_q[7:0];
                OFF_CMP_HI: rdata_d = cmp_q[15:8];
                OFF_CNT_LO: rdata_d = cnt_q[7:0];
                OFF_CNT_HI: rdata_d = shadow_q;
                OFF_STATUS: rdata_d = {6'b0, ovf_q, match_q};
                default:    rdata_d = 8'h00;
            endcase
            if (off == OFF_CNT_LO) shadow_d = cnt_q[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            cmp_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            pcnt_q   <= '0;
            rdata_q  <= '0;
            match_q  <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            cmp_q    <= cmp_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pcnt_q   <= pcnt_d;
            rdata_q  <= rdata_d;
            match_q  <= match_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    assign dMemIOOut = rdata_q;
    assign interrupt = irq_q;

endmodule
